// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator producing one-hot gt/eq/lt flags and a done strobe.
// Optional SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing bit pair instead of after WIDTH pairs.
module serial_magnitude_comparator #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic A_greater_B,
   output logic A_equals_B,
   output logic A_less_B
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          decided, decided_nxt;
   logic          gt, gt_nxt;
   logic          busy_nxt, done_nxt;
   logic          gt_flag_nxt, eq_flag_nxt, lt_flag_nxt;
   logic          first_diff;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         decided     <= 1'b0;
         gt          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         A_greater_B <= 1'b0;
         A_equals_B  <= 1'b0;
         A_less_B    <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         decided     <= decided_nxt;
         gt          <= gt_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         A_greater_B <= gt_flag_nxt;
         A_equals_B  <= eq_flag_nxt;
         A_less_B    <= lt_flag_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      decided_nxt = decided;
      gt_nxt      = gt;
      gt_flag_nxt = A_greater_B;
      eq_flag_nxt = A_equals_B;
      lt_flag_nxt = A_less_B;
      first_diff  = bit_valid && !decided && (a_bit != b_bit);

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt   = S_SHIFT;
               cnt_nxt     = '0;
               decided_nxt = 1'b0;
               gt_nxt      = 1'b0;
               gt_flag_nxt = 1'b0;
               eq_flag_nxt = 1'b0;
               lt_flag_nxt = 1'b0;
            end
         end
         S_SHIFT: begin
            if (bit_valid) begin
               if (first_diff) begin
                  decided_nxt = 1'b1;
                  gt_nxt      = a_bit;
               end
               // Counter holds at the last index so it never wraps inside a comparison
               if (cnt == LAST_IDX) begin
                  state_nxt = S_DONE;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
               if (first_diff) begin
                  state_nxt = S_DONE;
               end
`endif
            end
            if (state_nxt == S_DONE) begin
               gt_flag_nxt = decided_nxt & gt_nxt;
               lt_flag_nxt = decided_nxt & ~gt_nxt;
               eq_flag_nxt = ~decided_nxt;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_DONE);
   end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=8): vector table plus start/hold/reset sequences.
module tb_serial_magnitude_comparator;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst_n, start, bit_valid, a_bit, b_bit;
   logic busy, done, A_greater_B, A_equals_B, A_less_B;

   int total = 0;
   int bad   = 0;

   serial_magnitude_comparator #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
      .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
      .A_greater_B(A_greater_B), .A_equals_B(A_equals_B), .A_less_B(A_less_B)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      bit         alt;
      logic [2:0] flags;   // {gt, eq, lt}
      int         done_std;
      int         done_ee;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [2:0] flags();
      return {A_greater_B, A_equals_B, A_less_B};
   endfunction

   // Runs one comparison starting in cycle 0; extra start pulses at s0/s1 (-1 = none).
   task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input bit alt,
                          input int s0, input int s1, input int exp_done,
                          input logic [2:0] exp_flags, input string nm);
      int idx = 0;
      int ndone = 0;
      int done_at = -1;
      int busy_err = 0;
      logic [2:0] flags_at_done = 3'b000;
      logic [2:0] flags_mid = 3'b000;
      for (int c = 0; c <= exp_done + 1; c++) begin
         @(posedge clk);
         #1;
         start = (c == 0) || (c == s0) || (c == s1);
         if (c >= 1 && idx < int'(W) && (!alt || (c % 2 == 0))) begin
            bit_valid = 1'b1;
            a_bit     = a[W-1-idx];
            b_bit     = b[W-1-idx];
            idx++;
         end else begin
            bit_valid = 1'b0;
            a_bit     = 1'b0;
            b_bit     = 1'b0;
         end
         @(negedge clk);
         if (busy !== ((c >= 1) && (c <= exp_done))) busy_err++;
         if (done === 1'b1) begin
            ndone++;
            done_at = c;
            flags_at_done = flags();
         end
         if (c == 1) flags_mid = flags();
      end
      start = 1'b0;
      bit_valid = 1'b0;
      chk({nm, " done_count"}, 32'(ndone), 32'd1);
      chk({nm, " done_cycle"}, 32'(done_at), 32'(exp_done));
      chk({nm, " flags_at_done"}, 32'(flags_at_done), 32'(exp_flags));
      chk({nm, " flags_held"}, 32'(flags()), 32'(exp_flags));
      chk({nm, " busy_profile"}, 32'(busy_err), 32'd0);
      if (exp_done > 1) chk({nm, " flags_cleared"}, 32'(flags_mid), 32'd0);
   endtask

   initial begin
      logic [7:0] sa, sb;
      int exp_d;
      int hold_err;

      vecs[0] = '{8'hA5, 8'h5A, 1'b0, 3'b100,  9,  2};
      vecs[1] = '{8'h3C, 8'h3C, 1'b0, 3'b010,  9,  9};
      vecs[2] = '{8'h80, 8'h81, 1'b1, 3'b001, 17, 17};
      vecs[3] = '{8'h40, 8'h00, 1'b0, 3'b100,  9,  3};
      vecs[4] = '{8'h01, 8'h02, 1'b0, 3'b001,  9,  8};
      vecs[5] = '{8'hFF, 8'h00, 1'b0, 3'b100,  9,  2};
      vecs[6] = '{8'h00, 8'hFF, 1'b0, 3'b001,  9,  2};
      vecs[7] = '{8'hFE, 8'hFF, 1'b0, 3'b001,  9,  9};
      vecs[8] = '{8'h00, 8'h00, 1'b0, 3'b010,  9,  9};
      vecs[9] = '{8'h7F, 8'h80, 1'b0, 3'b001,  9,  2};

      rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_flags", 32'(flags()), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[i]) begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
         exp_d = vecs[i].done_ee;
`else
         exp_d = vecs[i].done_std;
`endif
         run_cmp(vecs[i].a, vecs[i].b, vecs[i].alt, -1, -1, exp_d, vecs[i].flags,
                 $sformatf("vec%0d", i));
      end

      // Equal result is held with no new start
      run_cmp(8'h3C, 8'h3C, 1'b0, -1, -1, 9, 3'b010, "eq_hold");
      hold_err = 0;
      for (int c = 11; c <= 15; c++) begin
         @(negedge clk);
         if (flags() !== 3'b010 || busy !== 1'b0) hold_err++;
      end
      chk("eq_hold_cycles", 32'(hold_err), 32'd0);

      // Start pulses while busy are ignored; operands chosen so the run lasts to cycle 9 in both builds
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      sa = 8'h01; sb = 8'h00;
`else
      sa = 8'hFF; sb = 8'h00;
`endif
      run_cmp(sa, sb, 1'b0, 3, 9, 9, 3'b100, "start_ignored");
      @(negedge clk);
      chk("start_ignored_idle", 32'(busy), 32'd0);

      // Reset clears held result flags
      #1 rst_n = 1'b0;
      #1;
      chk("reset_clears_held_flags", 32'(flags()), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset mid-comparison: start cycle 0, reset cycles 5-6, new start cycle 8
      @(posedge clk);
      #1 start = 1'b1; bit_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         #1 start = 1'b0; bit_valid = 1'b1;
         a_bit = sa[W-c]; b_bit = sb[W-c];
      end
      @(posedge clk);
      #1 rst_n = 1'b0; bit_valid = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_flags", 32'(flags()), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_idle_after_release", 32'(busy), 32'd0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      exp_d = 8;
`else
      exp_d = 9;
`endif
      run_cmp(8'h01, 8'h02, 1'b0, -1, -1, exp_d, 3'b001, "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
